// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared constants for the multi-cycle MIPS controller.
//   - FSM state encodings (4-bit, 13 states including the optional TRAP)
//   - Opcode constants for the supported instruction subset
//   - Encodings of the alu_op, alu_src_b and pc_source datapath selects
//   - op_class_t: one-hot instruction class produced by ctrl_opdecode
package multicycle_pkg;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_I_EXEC    = 4'd8;
    localparam logic [3:0] S_I_WB      = 4'd9;
    localparam logic [3:0] S_BRANCH    = 4'd10;
    localparam logic [3:0] S_JUMP      = 4'd11;
    localparam logic [3:0] S_TRAP      = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic rtype;
        logic lw;
        logic sw;
        logic beq;
        logic addi;
        logic ori;
        logic j;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/ctrl_opdecode.sv
// ctrl_opdecode: combinational opcode -> one-hot instruction class.
// Ports:
//   opcode   in  6  IR[31:26]
//   op_class out    one-hot class; exactly one field is set for any opcode
module ctrl_opdecode
    import multicycle_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    // Map each supported opcode to its class; everything else is illegal
    always_comb begin
        op_class = '0;
        case (opcode)
            OP_RTYPE: op_class.rtype   = 1'b1;
            OP_LW:    op_class.lw      = 1'b1;
            OP_SW:    op_class.sw      = 1'b1;
            OP_BEQ:   op_class.beq     = 1'b1;
            OP_ADDI:  op_class.addi    = 1'b1;
            OP_ORI:   op_class.ori     = 1'b1;
            OP_J:     op_class.j       = 1'b1;
            default:  op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing a multi-cycle MIPS datapath that
// shares one memory port and one ALU.
// Optional feature macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
//   defined   -> undefined opcodes enter a TRAP state held until reset and
//                the illegal_op output is present
//   undefined -> undefined opcodes retire as a 2-cycle NOP
// Ports:
//   clk, reset (sync, active high)
//   opcode, funct  IR fields; zero ALU flag; mem_ready memory handshake
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, ext_sel
//                  datapath controls
//   instr_done     pulse on an instruction's final cycle
//   illegal_op     sticky illegal-opcode flag (feature build only)
//   state          current FSM state for debug
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int ST_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic [OPC_W-1:0] funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             ext_sel,
    output logic             instr_done,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    output logic             illegal_op,
`endif
    output logic [ST_W-1:0]  state
);

    op_class_t       op_class;
    logic [ST_W-1:0] next_state;

    // funct is consumed by the datapath ALU control and zero by the branch
    // gate there; the FSM itself never needs them.
    logic unused_inputs;
    assign unused_inputs = ^{funct, zero};

    ctrl_opdecode u_opdecode (
        .opcode   (opcode),
        .op_class (op_class)
    );

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: begin
                if (mem_ready) next_state = S_DECODE;
                else           next_state = S_FETCH;
            end
            S_DECODE: begin
                if (op_class.rtype)                  next_state = S_R_EXEC;
                else if (op_class.lw || op_class.sw) next_state = S_MEM_ADDR;
                else if (op_class.beq)               next_state = S_BRANCH;
                else if (op_class.addi || op_class.ori) next_state = S_I_EXEC;
                else if (op_class.j)                 next_state = S_JUMP;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                else                                 next_state = S_TRAP;
`else
                else                                 next_state = S_FETCH;
`endif
            end
            // opcode stays valid in the IR for the whole instruction
            S_MEM_ADDR: begin
                if (op_class.sw) next_state = S_MEM_WRITE;
                else             next_state = S_MEM_READ;
            end
            S_MEM_READ: begin
                if (mem_ready) next_state = S_MEM_WB;
                else           next_state = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (mem_ready) next_state = S_FETCH;
                else           next_state = S_MEM_WRITE;
            end
            S_R_EXEC:  next_state = S_R_WB;
            S_I_EXEC:  next_state = S_I_WB;
            S_MEM_WB,
            S_R_WB,
            S_I_WB,
            S_BRANCH,
            S_JUMP:    next_state = S_FETCH;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:    next_state = S_TRAP;
`endif
            default:   next_state = S_FETCH;
        endcase
    end

    // Output decode: a function of state, qualified by mem_ready only where
    // a memory access completes
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        ext_sel       = 1'b0;
        instr_done    = 1'b0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        illegal_op    = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the class resolves
                alu_src_b = SRCB_IMM_SH2;
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                instr_done = op_class.illegal;
`endif
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_sel   = op_class.ori;
                if (op_class.ori) alu_op = ALU_OR;
                else              alu_op = ALU_ADD;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                ext_sel    = op_class.ori;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_op = 1'b1;
            end
`endif
            default: begin
                instr_done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table-driven per-cycle vectors
// followed by hand-written reset and illegal-opcode sequences.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_sel, instr_done;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .ext_sel       (ext_sel),
        .instr_done    (instr_done),
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        .illegal_op    (illegal_op),
`endif
        .state         (state)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write |
    //  reg_dst, mem_to_reg, reg_write, alu_src_a |
    //  alu_src_b, alu_op, pc_source | ext_sel, instr_done}
    logic [17:0] ctrl;
    assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a,
                   alu_src_b, alu_op, pc_source, ext_sel, instr_done};

    localparam logic [17:0] C_F1      = 18'b100101_0000_010000_00;
    localparam logic [17:0] C_F0      = 18'b000100_0000_010000_00;
    localparam logic [17:0] C_DEC     = 18'b000000_0000_110000_00;
    localparam logic [17:0] C_DEC_ILL = 18'b000000_0000_110000_01;
    localparam logic [17:0] C_MA      = 18'b000000_0001_100000_00;
    localparam logic [17:0] C_MR      = 18'b001100_0000_000000_00;
    localparam logic [17:0] C_MWB     = 18'b000000_0110_000000_01;
    localparam logic [17:0] C_MW1     = 18'b001010_0000_000000_01;
    localparam logic [17:0] C_MW0     = 18'b001010_0000_000000_00;
    localparam logic [17:0] C_REX     = 18'b000000_0001_001000_00;
    localparam logic [17:0] C_RWB     = 18'b000000_1010_000000_01;
    localparam logic [17:0] C_IADD    = 18'b000000_0001_100000_00;
    localparam logic [17:0] C_IORI    = 18'b000000_0001_101100_10;
    localparam logic [17:0] C_WBADD   = 18'b000000_0010_000000_01;
    localparam logic [17:0] C_WBORI   = 18'b000000_0010_000000_11;
    localparam logic [17:0] C_BR      = 18'b010000_0001_000101_01;
    localparam logic [17:0] C_J       = 18'b100000_0000_000010_01;

    localparam logic [3:0] FE = 4'd0,  DE = 4'd1,  MA = 4'd2,  MR = 4'd3;
    localparam logic [3:0] MB = 4'd4,  MW = 4'd5,  RX = 4'd6,  RB = 4'd7;
    localparam logic [3:0] IX = 4'd8,  IB = 4'd9,  BR = 4'd10, JP = 4'd11;
    localparam logic [3:0] TR = 4'd12;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] AD = 6'b001000, OR = 6'b001101, BQ = 6'b000100;
    localparam logic [5:0] JJ = 6'b000010, IL = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic        zf;
        logic [3:0]  st;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic [5:0] op, input logic rdy,
                                input logic zf, input logic [3:0] st,
                                input logic [17:0] exp);
        vec_t v;
        v.op = op; v.rdy = rdy; v.zf = zf; v.st = st; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = RT; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b0;

        // lw, no stalls: 5 cycles
        add(LW,1,0,FE,C_F1); add(LW,1,0,DE,C_DEC); add(LW,1,0,MA,C_MA);
        add(LW,1,0,MR,C_MR); add(LW,1,0,MB,C_MWB);
        // sw with 3 stall cycles in MEM_WRITE: 7 cycles
        add(SW,1,0,FE,C_F1); add(SW,1,0,DE,C_DEC); add(SW,1,0,MA,C_MA);
        add(SW,0,0,MW,C_MW0); add(SW,0,0,MW,C_MW0); add(SW,0,0,MW,C_MW0);
        add(SW,1,0,MW,C_MW1);
        // R-type with 2 fetch stall cycles
        add(RT,0,0,FE,C_F0); add(RT,0,0,FE,C_F0); add(RT,1,0,FE,C_F1);
        add(RT,1,0,DE,C_DEC); add(RT,1,0,RX,C_REX); add(RT,1,0,RB,C_RWB);
        // addi then ori
        add(AD,1,0,FE,C_F1); add(AD,1,0,DE,C_DEC); add(AD,1,0,IX,C_IADD);
        add(AD,1,0,IB,C_WBADD);
        add(OR,1,0,FE,C_F1); add(OR,1,0,DE,C_DEC); add(OR,1,0,IX,C_IORI);
        add(OR,1,0,IB,C_WBORI);
        // beq with zero = 1, then j
        add(BQ,1,1,FE,C_F1); add(BQ,1,1,DE,C_DEC); add(BQ,1,1,BR,C_BR);
        add(JJ,1,0,FE,C_F1); add(JJ,1,0,DE,C_DEC); add(JJ,1,0,JP,C_J);
        // lw with one stall cycle in MEM_READ
        add(LW,1,0,FE,C_F1); add(LW,1,0,DE,C_DEC); add(LW,1,0,MA,C_MA);
        add(LW,0,0,MR,C_MR); add(LW,1,0,MR,C_MR); add(LW,1,0,MB,C_MWB);
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        // undefined opcode retires as a 2-cycle NOP
        add(IL,1,0,FE,C_F1); add(IL,1,0,DE,C_DEC_ILL);
`endif
        add(RT,0,0,FE,C_F0);

        // reset state, reset still asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", {28'd0, state}, {28'd0, FE});
        chk("reset_ctrl", {14'd0, ctrl}, {14'd0, C_F0});
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        chk("reset_illegal", {31'd0, illegal_op}, 32'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].op; mem_ready = vecs[i].rdy; zero = vecs[i].zf;
            #1;
            chk($sformatf("v%0d_state", i), {28'd0, state}, {28'd0, vecs[i].st});
            chk($sformatf("v%0d_ctrl", i), {14'd0, ctrl}, {14'd0, vecs[i].exp});
            chk($sformatf("v%0d_excl", i),
                {30'd0, mem_read & mem_write, reg_write & mem_write}, 32'd0);
            @(negedge clk);
        end

        // reset held 2 cycles while stalled in MEM_READ
        opcode = LW; mem_ready = 1'b1;
        #1;
        chk("pre_lw_state", {28'd0, state}, {28'd0, FE});
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("mid_memread", {28'd0, state}, {28'd0, MR});
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst%0d_state", c), {28'd0, state}, {28'd0, FE});
            chk($sformatf("rst%0d_nowrite", c), {30'd0, reg_write, mem_write}, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_ctrl", {14'd0, ctrl}, {14'd0, C_F0});
        @(negedge clk);
        #1;
        chk("post_rst_hold", {28'd0, state}, {28'd0, FE});

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        // undefined opcode traps until reset
        opcode = IL; mem_ready = 1'b1;
        #1;
        chk("ill_fetch", {14'd0, ctrl}, {14'd0, C_F1});
        @(negedge clk);
        #1;
        chk("ill_decode", {14'd0, ctrl}, {14'd0, C_DEC});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("trap%0d_state", c), {28'd0, state}, {28'd0, TR});
            chk($sformatf("trap%0d_ctrl", c), {14'd0, ctrl}, 32'd0);
            chk($sformatf("trap%0d_flag", c), {31'd0, illegal_op}, 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("trap_exit_state", {28'd0, state}, {28'd0, FE});
        chk("trap_exit_flag", {31'd0, illegal_op}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style FSM that sequences a multi-cycle MIPS datapath over one shared memory port and one ALU.
- Decodes opcode/funct and steps each instruction through fetch, decode, execute, memory and writeback.
- Drives all mux selects and write enables, including ext_sel, which chooses sign or zero extension of the 16-bit immediate.
- Sits between the instruction register and the datapath; the only handshake is with the memory port.

Parameters:
- OPC_W, 6, opcode/funct field width.
- ST_W, 4, state register width (13 states max).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory port has completed the current access.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when zero=1 (branch).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = or.
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ext_sel  out  1  0 = sign-extend, 1 = zero-extend.
- instr_done  out  1  one-cycle pulse on an instruction's final cycle.
- state  out  ST_W  current state, for debug.
- illegal_op  out  1  sticky flag; exists only with the optional feature.

Behaviour:
- Reset: reset sampled high sets state to FETCH at that edge.
  - While state = FETCH with mem_ready = 0, all enables are 0 except mem_read.
  - illegal_op clears to 0.
  - Reset mid-instruction abandons the instruction; no write is issued after the reset edge.
- Outputs are a pure function of state. Exceptions: ir_write, pc_write and the FETCH/MEM_* exits are further qualified by mem_ready.
  - Every signal not listed for a state is 0.
- FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write = pc_write = mem_ready.
  - Hold until mem_ready = 1, then go to DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (precompute branch target). Next state by opcode:
  - 000000 → R_EXEC.
  - 100011 or 101011 → MEM_ADDR.
  - 000100 → BRANCH.
  - 001000 or 001101 → I_EXEC.
  - 000010 → JUMP.
  - Any other opcode → FETCH with instr_done = 1 (executes as a NOP).
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00, ext_sel = 0. Go to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read = 1, iord = 1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1. Go to FETCH.
- MEM_WRITE: mem_write = 1, iord = 1. Hold until mem_ready; on the mem_ready cycle instr_done = 1, then go to FETCH.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Go to R_WB.
- R_WB: reg_write = 1, reg_dst = 1, instr_done = 1. Go to FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 10.
  - addi: alu_op = 00, ext_sel = 0.
  - ori: alu_op = 11, ext_sel = 1.
  - Go to I_WB.
- I_WB: reg_write = 1, reg_dst = 0, ext_sel held from I_EXEC opcode, instr_done = 1. Go to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01, instr_done = 1. Go to FETCH.
- JUMP: pc_write = 1, pc_source = 10, instr_done = 1. Go to FETCH.
- Cycle counts with mem_ready tied to 1:
  - lw 5; sw 4; R-type 4; addi/ori 4; beq 3; j 3; illegal 2.
  - Each extra mem_ready = 0 cycle adds 1.
- mem_read and mem_write are never both 1. reg_write is never 1 in the same cycle as mem_write.
- Unreachable state encodings return to FETCH on the next edge.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode in DECODE goes to state TRAP.
  - In TRAP all enables are 0 and illegal_op = 1. The FSM stays in TRAP until reset.
- Undefined:
  - The illegal_op port and the TRAP state are absent.
  - An undefined opcode acts as a 2-cycle NOP, as above.

Decomposition:
- Package multicycle_pkg holds:
  - State encodings (localparams).
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J.
  - Encodings for alu_op, alu_src_b and pc_source.
- One sub-module, ctrl_opdecode: a combinational opcode → instruction-class one-hot, used by DECODE and I_EXEC.
- The FSM and the output decode stay in multicycle_ctrl.

Test Plan:
- Reset: hold reset 2 cycles mid-MEM_READ → state = FETCH; reg_write and mem_write stay 0; mem_read = 1 on the first post-reset cycle.
- lw (opcode 100011), mem_ready = 1 → state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; instr_done in cycle 5 only; mem_to_reg = 1 and reg_write = 1 there.
- sw with mem_ready low 3 cycles in MEM_WRITE → mem_write held 4 cycles; instr_done only on the mem_ready cycle; total 7 cycles.
- ori (001101) → ext_sel = 1 and alu_op = 11 in I_EXEC; addi (001000) → ext_sel = 0 and alu_op = 00.
- beq (000100) with zero = 1, then j (000010) → BRANCH: pc_write_cond = 1, pc_source = 01, alu_op = 01; JUMP: pc_write = 1, pc_source = 10; 3 cycles each.
- Opcode 111111 → without the macro, returns to FETCH after 2 cycles with instr_done = 1; with the macro, state = TRAP, illegal_op = 1 held until reset.
